// File: rtl/mem_pkg.sv
// Shared types and defaults for the cache request arbiter: FSM states,
// transaction owner encoding and default bus widths.
package mem_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;
    localparam int CNT_W_DEF  = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_e;

    // OWN_I is the reset value of the last-grant bit, so d wins the first tie.
    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_e;

endpackage

// File: rtl/cache_arbiter_if.sv
// Request/response channel shared by the fetch port, the data port and the
// cache-controller port. The requester side uses master, the responder side uses slave.
interface cache_arbiter_if
    import mem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) ();

    logic              req_valid;
    logic              req_ready;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              resp_valid;
    logic [DATA_W-1:0] rdata;

    modport master (
        output req_valid, we, addr, wdata,
        input  req_ready, resp_valid, rdata
    );

    modport slave (
        input  req_valid, we, addr, wdata,
        output req_ready, resp_valid, rdata
    );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin chooser: bit 0 is the fetch requester, bit 1 the data
// requester; a tie goes to the side that did not win last time.
module rr_arb2
    import mem_pkg::*;
(
    input  logic [1:0] req,
    input  owner_e     last_grant,
    output logic [1:0] gnt
);

    // One-hot grant selection.
    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = (last_grant == OWN_D) ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/cache_arbiter.sv
// Arbitrates instruction-fetch and data requests onto a single cache controller
// port with at most one transaction outstanding, plus saturating grant counters.
module cache_arbiter
    import mem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    cache_arbiter_if.slave     i_port,
    cache_arbiter_if.slave     d_port,
    cache_arbiter_if.master    c_port,
    output logic [CNT_W-1:0]   i_grant_cnt,
    output logic [CNT_W-1:0]   d_grant_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1'b1);

    state_e            state_r;
    state_e            state_next_s;
    owner_e            owner_r;
    owner_e            last_grant_r;
    logic [1:0]        gnt_s;
    logic              accept_s;
    logic              lat_we_r;
    logic [ADDR_W-1:0] lat_addr_r;
    logic [DATA_W-1:0] lat_wdata_r;
    logic [CNT_W-1:0]  i_cnt_r;
    logic [CNT_W-1:0]  d_cnt_r;
    logic              unused_fetch_fields_s;

    // The fetch channel never writes, so its write fields are ignored.
    assign unused_fetch_fields_s = ^{i_port.we, i_port.wdata};

    rr_arb2 u_rr_arb2 (
        .req        ({d_port.req_valid, i_port.req_valid}),
        .last_grant (last_grant_r),
        .gnt        (gnt_s)
    );

    assign accept_s    = (state_r == ST_IDLE) && !rst && (gnt_s != 2'b00);
    assign i_grant_cnt = rst ? {CNT_W{1'b0}} : i_cnt_r;
    assign d_grant_cnt = rst ? {CNT_W{1'b0}} : d_cnt_r;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) state_next_s = ST_ISSUE;
                else          state_next_s = ST_IDLE;
            end
            ST_ISSUE: begin
                if (c_port.req_ready) state_next_s = ST_WAIT;
                else                  state_next_s = ST_ISSUE;
            end
            ST_WAIT: begin
                if (c_port.resp_valid) state_next_s = ST_IDLE;
                else                   state_next_s = ST_WAIT;
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Output decode; cache responses outside WAIT fall through unused.
    always_comb begin
        i_port.req_ready  = 1'b0;
        i_port.resp_valid = 1'b0;
        i_port.rdata      = {DATA_W{1'b0}};
        d_port.req_ready  = 1'b0;
        d_port.resp_valid = 1'b0;
        d_port.rdata      = {DATA_W{1'b0}};
        c_port.req_valid  = 1'b0;
        c_port.we         = 1'b0;
        c_port.addr       = {ADDR_W{1'b0}};
        c_port.wdata      = {DATA_W{1'b0}};
        if (!rst) begin
            case (state_r)
                ST_IDLE: begin
                    i_port.req_ready = gnt_s[0];
                    d_port.req_ready = gnt_s[1];
                end
                ST_ISSUE: begin
                    c_port.req_valid = 1'b1;
                    c_port.we        = lat_we_r;
                    c_port.addr      = lat_addr_r;
                    c_port.wdata     = lat_wdata_r;
                end
                ST_WAIT: begin
                    if (c_port.resp_valid && (owner_r == OWN_I)) begin
                        i_port.resp_valid = 1'b1;
                        i_port.rdata      = c_port.rdata;
                    end else if (c_port.resp_valid) begin
                        d_port.resp_valid = 1'b1;
                        d_port.rdata      = lat_we_r ? {DATA_W{1'b0}} : c_port.rdata;
                    end else begin
                        c_port.req_valid  = 1'b0;
                    end
                end
                default: c_port.req_valid = 1'b0;
            endcase
        end else begin
            c_port.req_valid = 1'b0;
        end
    end

    // Latch the winner's request, record ownership and count grants.
    always_ff @(posedge clk) begin
        if (rst) begin
            owner_r      <= OWN_I;
            last_grant_r <= OWN_I;
            lat_we_r     <= 1'b0;
            lat_addr_r   <= {ADDR_W{1'b0}};
            lat_wdata_r  <= {DATA_W{1'b0}};
            i_cnt_r      <= {CNT_W{1'b0}};
            d_cnt_r      <= {CNT_W{1'b0}};
        end else if (accept_s && gnt_s[1]) begin
            owner_r      <= OWN_D;
            last_grant_r <= OWN_D;
            lat_we_r     <= d_port.we;
            lat_addr_r   <= {d_port.addr[ADDR_W-1:2], 2'b00};
            lat_wdata_r  <= d_port.wdata;
            if (d_cnt_r != CNT_MAX) d_cnt_r <= d_cnt_r + CNT_ONE;
            else                    d_cnt_r <= d_cnt_r;
        end else if (accept_s) begin
            owner_r      <= OWN_I;
            last_grant_r <= OWN_I;
            lat_we_r     <= 1'b0;
            lat_addr_r   <= {i_port.addr[ADDR_W-1:2], 2'b00};
            lat_wdata_r  <= {DATA_W{1'b0}};
            if (i_cnt_r != CNT_MAX) i_cnt_r <= i_cnt_r + CNT_ONE;
            else                    i_cnt_r <= i_cnt_r;
        end else begin
            owner_r      <= owner_r;
            last_grant_r <= last_grant_r;
        end
    end

endmodule

// File: doc/cache_arbiter.md
CACHE_ARBITER -- requirements
Module: cache_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, request address width.
REQ-002 Parameter DATA_W, default 32, data width.
REQ-003 Parameter CNT_W, default 16, grant-counter width.
REQ-004 clk  in  1  clock; all state on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 i_req_valid  in  1  instruction-fetch read request.
REQ-007 i_req_ready  out  1  instruction request accepted this cycle.
REQ-008 i_addr  in  ADDR_W  fetch address.
REQ-009 i_resp_valid  out  1  one-cycle fetch response pulse.
REQ-010 i_rdata  out  DATA_W  fetch data, valid with i_resp_valid.
REQ-011 d_req_valid  in  1  data-memory request.
REQ-012 d_req_ready  out  1  data request accepted this cycle.
REQ-013 d_we  in  1  1 = write, 0 = read.
REQ-014 d_addr  in  ADDR_W  data address.
REQ-015 d_wdata  in  DATA_W  write data.
REQ-016 d_resp_valid  out  1  one-cycle response pulse; read data or write acknowledge.
REQ-017 d_rdata  out  DATA_W  read data; 0 for write acknowledge.
REQ-018 c_req_valid  out  1  request to cache controller.
REQ-019 c_req_ready  in  1  cache controller accepts request.
REQ-020 c_we, c_addr, c_wdata  out  1/ADDR_W/DATA_W  forwarded request fields.
REQ-021 c_resp_valid  in  1  cache response pulse.
REQ-022 c_rdata  in  DATA_W  cache read data.
REQ-023 i_grant_cnt, d_grant_cnt  out  CNT_W each  saturating grant counters.

Function
REQ-024 FSM states: IDLE, ISSUE, WAIT; at most one request outstanding.
REQ-025 IDLE: if any request is valid, assert ready (combinationally) to exactly one winner, latch its fields, record owner, and go to ISSUE.
REQ-026 Arbitration is round-robin via a last-grant bit; when both requesters are valid, the requester not granted last wins; after reset, d wins the first tie.
REQ-027 A single valid requester is granted regardless of the last-grant bit.
REQ-028 ready is 0 in ISSUE and WAIT; requesters hold valid/fields until ready.
REQ-029 ISSUE: c_req_valid = 1 with latched fields held stable; on c_req_valid && c_req_ready, go to WAIT.
REQ-030 c_addr = latched address with bits [1:0] forced to 0; c_we = 0 for i requests.
REQ-031 WAIT: on c_resp_valid, pulse the owner's resp_valid for exactly one cycle that same cycle (combinational pass-through of c_rdata), then go to IDLE.
REQ-032 Minimum latency: accept at cycle N, c_req_valid at N+1, next grant no earlier than the cycle after the response.
REQ-033 c_resp_valid in IDLE or ISSUE is ignored; non-owner resp_valid stays 0.
REQ-034 Grant counter increments on each accept for its requester and saturates at all-ones.

Reset
REQ-035 rst in any state forces IDLE, aborts any outstanding transaction with no response, and clears the last-grant bit (d favoured).
REQ-036 During and after reset: all ready, resp_valid, and c_req_valid outputs are 0; c_we, c_addr, c_wdata, rdata outputs and both counters are 0.

Structure
REQ-037 Shared package mem_pkg holds the FSM state enum, owner enum (OWN_I, OWN_D), and the ADDR_W/DATA_W defaults.
REQ-038 Round-robin choice sits in sub-module rr_arb2 (2 requests, last-grant input, one-hot grant output); everything else stays flat.

Verification
REQ-039 i only, i_addr=0x1003, c_req_ready=1, c_rdata=0xDEADBEEF two cycles later -> c_addr=0x1000, c_we=0, i_resp_valid 1 cycle, i_rdata=0xDEADBEEF.
REQ-040 Both valid at once, first cycle after reset -> d granted first, i granted on the next IDLE, and c_req_valid never asserted in WAIT.
REQ-041 d write 0x20=0x55 with c_req_ready held 0 for 5 cycles -> c_req_valid and fields stable for all 5 cycles; d_resp_valid pulses with d_rdata=0 after c_resp_valid.
REQ-042 Spurious c_resp_valid in IDLE -> no resp_valid on either port.
REQ-043 rst asserted in WAIT, then a late c_resp_valid -> no response to the owner; next tie grants d.
REQ-044 CNT_W=2, five i grants -> i_grant_cnt reads 1,2,3,3,3.
